ps2_key_event_rx: RTL



---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_sync_edge.sv | 49 ++++
 rtl/ps2_key_event_rx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 key-event receiver:
//   - prefix byte constants (E0 extended, F0 break) and frame geometry
//   - default watchdog length (1 ms at 50 MHz)
//   - frame FSM state enum (IDLE, SHIFT, CHECK)
//   - key event struct {code, ext, brk}
//   - frame_ok(): validity check on the 10 bits captured after the start bit
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT      = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK      = 8'hF0;
  localparam int         PS2_FRAME_BITS      = 11;
  localparam int         PS2_TIMEOUT_DEFAULT = 50000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } frame_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_event_t;

  // bits[7:0] = data (LSB first on the wire), bits[8] = parity, bits[9] = stop.
  // Good frame: odd ones-count over data+parity and stop high.
  function automatic logic frame_ok(input logic [9:0] bits);
    return (^bits[8:0]) & bits[9];
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Brings the raw, asynchronous PS/2 lines into the clk domain and produces a
// one-cycle falling-edge strobe of the synchronised PS/2 clock.
//
// Parameters:
//   SYNC_STAGES  flop depth of each synchroniser (2..4)
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   ps_clk     in   raw PS/2 clock
//   ps_data    in   raw PS/2 data
//   sync_data  out  synchronised PS/2 data, aligned with fe
//   fe         out  one-cycle strobe: synced ps_clk was 1 last cycle, 0 now
// ---------------------------------------------------------------------------
module ps2_sync_edge
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps_clk,
  input  logic ps_data,
  output logic sync_data,
  output logic fe
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;

  // Chains reset to 1 (idle bus level) so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_data = data_sync_q[SYNC_STAGES-1];
  assign fe        = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_key_event_rx.sv
// ---------------------------------------------------------------------------
// ps2_key_event_rx
// PS/2 keyboard receiver: deframes 11-bit frames (start/8 data/parity/stop),
// aborts stalled frames with a watchdog, folds E0/F0 prefixes into the
// following key byte and emits one event per key.
//
// Optional build macro TYPEMATIC_FILTER_EN: suppresses auto-repeat makes by
// remembering the last emitted make {valid, ext, code}.
//
// Parameters:
//   TIMEOUT_CYCLES  clk cycles without a ps_clk falling edge before a
//                   partial frame is aborted
//   SYNC_STAGES     synchroniser depth (2..4)
// Ports:
//   clk        in   50 MHz system clock
//   reset      in   asynchronous active-high reset
//   ps_clk     in   raw PS/2 clock
//   ps_data    in   raw PS/2 data
//   key_code   out  scan code of the last event (held until the next event)
//   key_ext    out  last event was E0-prefixed
//   key_break  out  last event was F0-prefixed (release)
//   key_valid  out  one-cycle event strobe
//   frame_err  out  one-cycle strobe: bad frame or watchdog abort
//   busy       out  a frame is partially received
//
// Handshake: key_valid and frame_err are pure strobes with no ready/back
// pressure; a consumer must take key_code/key_ext/key_break in the cycle
// key_valid is high (they stay stable afterwards until the next event).
// The two strobes are never high together.
// The frame FSM state is visible as state_q (frame_state_e).
// ---------------------------------------------------------------------------
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps_clk,
  input  logic       ps_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic sync_data;
  logic fe;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps_clk   (ps_clk),
    .ps_data  (ps_data),
    .sync_data(sync_data),
    .fe       (fe)
  );

  frame_state_e state_q, state_d;
  logic [3:0]   bit_cnt_q, bit_cnt_d;
  logic [9:0]   shreg_q, shreg_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic         ext_pend_q, ext_pend_d;
  logic         brk_pend_q, brk_pend_d;
  key_event_t   key_q, key_d;
  logic         key_valid_q, key_valid_d;
  logic         frame_err_q, frame_err_d;
  logic         emit;
  logic [7:0]   rx_byte;

`ifdef TYPEMATIC_FILTER_EN
  logic         lm_valid_q, lm_valid_d;
  logic         lm_ext_q, lm_ext_d;
  logic [7:0]   lm_code_q, lm_code_d;
  logic         lm_match;
`endif

  assign rx_byte = shreg_q[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      wd_q        <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      wd_q        <= wd_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lm_valid_q <= 1'b0;
      lm_ext_q   <= 1'b0;
      lm_code_q  <= '0;
    end else begin
      lm_valid_q <= lm_valid_d;
      lm_ext_q   <= lm_ext_d;
      lm_code_q  <= lm_code_d;
    end
  end

  assign lm_match = lm_valid_q && (lm_ext_q == ext_pend_q) && (lm_code_q == rx_byte);
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    wd_d        = wd_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    emit        = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
    lm_valid_d  = lm_valid_q;
    lm_ext_d    = lm_ext_q;
    lm_code_d   = lm_code_q;
`endif

    case (state_q)
      IDLE: begin
        // A falling edge with data high is not a start bit; ignore it.
        if (fe && !sync_data) begin
          state_d   = SHIFT;
          bit_cnt_d = 4'd1;
          wd_d      = WD_W'(1);
        end
      end

      SHIFT: begin
        if (fe) begin
          // LSB first: after 10 shifts shreg = {stop, parity, data[7:0]}.
          shreg_d   = {sync_data, shreg_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          wd_d      = WD_W'(1);
          if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
            state_d = CHECK;
          end
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // wd_q counts cycles since the last edge; this cycle makes it
          // TIMEOUT_CYCLES, so the abort strobe lands exactly then.
          state_d     = IDLE;
          frame_err_d = 1'b1;
          ext_pend_d  = 1'b0;
          brk_pend_d  = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
          lm_valid_d  = 1'b0;
`endif
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      CHECK: begin
        state_d = IDLE;
        if (!frame_ok(shreg_q)) begin
          // A corrupted frame might have been a prefix; drop pending ones.
          frame_err_d = 1'b1;
          ext_pend_d  = 1'b0;
          brk_pend_d  = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
          lm_valid_d  = 1'b0;
`endif
        end else if (rx_byte == PS2_PREFIX_EXT) begin
          ext_pend_d = 1'b1;
        end else if (rx_byte == PS2_PREFIX_BRK) begin
          brk_pend_d = 1'b1;
        end else begin
          emit = 1'b1;
`ifdef TYPEMATIC_FILTER_EN
          if (!brk_pend_q) begin
            if (lm_match) begin
              emit = 1'b0;
            end else begin
              lm_valid_d = 1'b1;
              lm_ext_d   = ext_pend_q;
              lm_code_d  = rx_byte;
            end
          end else if (lm_match) begin
            lm_valid_d = 1'b0;
          end
`endif
          if (emit) begin
            key_d.code  = rx_byte;
            key_d.ext   = ext_pend_q;
            key_d.brk   = brk_pend_q;
            key_valid_d = 1'b1;
          end
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign key_code  = key_q.code;
  assign key_ext   = key_q.ext;
  assign key_break = key_q.brk;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule
